// File: rtl/bogatyri_nonce_scheduler.sv
// rtl/bogatyri_nonce_scheduler.sv - on-demand nonce chunk dispatcher and found-nonce arbiter
module bogatyri_nonce_scheduler #(
  parameter int NUM_WORKERS   = 27,
  parameter int NONCE_W       = 32,
  parameter int CHUNK_LOG2    = 16,
  parameter bit STOP_ON_FOUND = 1'b1,
  parameter int WID_W         = $clog2(NUM_WORKERS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           job_valid,
  output logic                           job_ready,
  input  logic [NONCE_W-1:0]             job_start,
  input  logic [NONCE_W-1:0]             job_last,
  input  logic                           abort,
  input  logic [NUM_WORKERS-1:0]         req,
  output logic [NUM_WORKERS-1:0]         grant,
  output logic [NONCE_W-1:0]             grant_base,
  output logic [CHUNK_LOG2:0]            grant_len,
  input  logic [NUM_WORKERS-1:0]         found_in,
  input  logic [NUM_WORKERS*NONCE_W-1:0] found_nonce_in,
  output logic [NUM_WORKERS-1:0]         found_ack,
  output logic                           found_valid,
  input  logic                           found_ready,
  output logic [NONCE_W-1:0]             found_nonce,
  output logic [WID_W-1:0]               found_worker,
  output logic                           job_done,
  output logic [1:0]                     done_reason,
  output logic [31:0]                    chunks_issued
);

  // Cursor carries one extra bit so a job ending at the all-ones nonce cannot wrap.
  localparam int CW = NONCE_W + 1;
  localparam int LW = CHUNK_LOG2 + 1;
  localparam logic [CW-1:0] CHUNK_FULL = CW'(1) << CHUNK_LOG2;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CW-1:0]      cursor;
  logic [NONCE_W-1:0] job_last_r;
  logic [WID_W-1:0]   rr_ptr;
  logic [WID_W-1:0]   found_ptr;

  // First set bit of vec at or after ptr, wrapping at NUM_WORKERS; returns {hit, index}.
  function automatic logic [WID_W:0] rr_pick(input logic [NUM_WORKERS-1:0] vec,
                                             input logic [WID_W-1:0] ptr);
    logic             hit;
    logic [WID_W-1:0] sel;
    logic [WID_W:0]   pos;
    hit = 1'b0;
    sel = '0;
    for (int k = 0; k < NUM_WORKERS; k++) begin
      pos = {1'b0, ptr} + (WID_W+1)'(k);
      if (pos >= (WID_W+1)'(NUM_WORKERS)) pos = pos - (WID_W+1)'(NUM_WORKERS);
      if (!hit && vec[pos[WID_W-1:0]]) begin
        hit = 1'b1;
        sel = pos[WID_W-1:0];
      end
    end
    return {hit, sel};
  endfunction

  // Pointer advance: one past the winner, wrapping to worker 0.
  function automatic logic [WID_W-1:0] next_ptr(input logic [WID_W-1:0] sel);
    return (sel == WID_W'(NUM_WORKERS - 1)) ? '0 : sel + 1'b1;
  endfunction

  // Per-worker nonce view of the flattened found bus.
  logic [NONCE_W-1:0] nonce_arr [NUM_WORKERS];
  for (genvar g = 0; g < NUM_WORKERS; g++) begin : g_unpack
    assign nonce_arr[g] = found_nonce_in[g*NONCE_W +: NONCE_W];
  end

  logic [CW-1:0]          last_ext;
  logic [CW-1:0]          remaining;
  logic [LW-1:0]          chunk_len;
  logic                   exhausted;
  logic                   found_hs;
  logic                   stop_found;
  logic                   end_event;
  logic [WID_W:0]         grant_pick;
  logic [WID_W-1:0]       grant_sel;
  logic [NUM_WORKERS-1:0] grant_onehot;
  logic [WID_W:0]         found_pick;
  logic [WID_W-1:0]       found_sel;
  logic                   found_load;

  assign job_ready  = (state == IDLE) && !abort;
  assign last_ext   = {1'b0, job_last_r};
  assign exhausted  = cursor > last_ext;
  assign remaining  = last_ext - cursor + CW'(1);
  assign chunk_len  = (remaining >= CHUNK_FULL) ? CHUNK_FULL[LW-1:0] : remaining[LW-1:0];
  assign found_hs   = found_valid && found_ready;
  assign stop_found = STOP_ON_FOUND && found_hs;
  assign end_event  = abort || stop_found || exhausted;

  // Last cycle's grant masks its worker, whose req is still high while it sees the grant.
  assign grant_pick   = rr_pick(req & ~grant, rr_ptr);
  assign grant_sel    = grant_pick[WID_W-1:0];
  assign grant_onehot = NUM_WORKERS'(1) << grant_sel;

  // Same masking for found flags: the acked worker drops found_in one cycle later.
  assign found_pick = rr_pick(found_in & ~found_ack, found_ptr);
  assign found_sel  = found_pick[WID_W-1:0];
  assign found_load = !found_valid || found_ready;

  // Job FSM: accepts jobs, issues chunk grants, and reports the job end with its reason.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cursor        <= '0;
      job_last_r    <= '0;
      rr_ptr        <= '0;
      grant         <= '0;
      grant_base    <= '0;
      grant_len     <= '0;
      job_done      <= 1'b0;
      done_reason   <= 2'd0;
      chunks_issued <= '0;
    end else begin
      job_done   <= 1'b0;
      grant      <= '0;
      grant_base <= '0;
      grant_len  <= '0;
      case (state)
        IDLE: begin
          if (job_valid && job_ready) begin
            state         <= RUN;
            cursor        <= {1'b0, job_start};
            job_last_r    <= job_last;
            chunks_issued <= '0;
          end
        end
        RUN: begin
          if (end_event) begin
            state       <= IDLE;
            job_done    <= 1'b1;
            done_reason <= abort ? 2'd2 : (stop_found ? 2'd1 : 2'd0);
          end else if (grant_pick[WID_W]) begin
            grant      <= grant_onehot;
            grant_base <= cursor[NONCE_W-1:0];
            grant_len  <= chunk_len;
            cursor     <= cursor + CW'(chunk_len);
            rr_ptr     <= next_ptr(grant_sel);
            if (chunks_issued != 32'hFFFF_FFFF) chunks_issued <= chunks_issued + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Found path: one-entry output register refilled round-robin from worker found flags in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found_valid  <= 1'b0;
      found_nonce  <= '0;
      found_worker <= '0;
      found_ack    <= '0;
      found_ptr    <= '0;
    end else begin
      found_ack <= '0;
      if (found_load) begin
        if (found_pick[WID_W]) begin
          found_valid  <= 1'b1;
          found_nonce  <= nonce_arr[found_sel];
          found_worker <= found_sel;
          found_ack    <= NUM_WORKERS'(1) << found_sel;
          found_ptr    <= next_ptr(found_sel);
        end else begin
          found_valid <= 1'b0;
        end
      end
    end
  end

endmodule
